// File: rtl/march_engine.sv
// rtl/march_engine.sv - March C- sequencer: drives memory strobes, checks reads, pulses stop.
module march_engine #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_tmode,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_wdata,
   output logic              o_we,
   output logic              o_re,
   output logic              o_stop,
   output logic              o_fail,
   output logic [ADDR_W-1:0] o_fail_addr,
   output logic [2:0]        o_fail_elem
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_t              r_state;
   state_t              w_next;
   logic [2:0]          r_elem;
   logic                r_phase;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_exp_valid;
   logic [DATA_W-1:0]   r_exp_data;
   logic [ADDR_W-1:0]   r_exp_addr;
   logic [2:0]          r_exp_elem;
   logic                r_stop;
   logic                r_fail;
   logic [ADDR_W-1:0]   r_fail_addr;
   logic [2:0]          r_fail_elem;

   logic w_two_op, w_down, w_addr_last, w_op_done, w_last_op;
   logic w_start, w_active, w_is_read, w_is_write, w_wr_one, w_rd_one, w_mismatch;

   // Elements 1..4 are read-then-write pairs; 3 and 4 walk the address space downward.
   assign w_two_op    = (r_elem >= 3'd1) && (r_elem <= 3'd4);
   assign w_down      = (r_elem == 3'd3) || (r_elem == 3'd4);
   assign w_addr_last = w_down ? (r_addr == '0) : (r_addr == ADDR_MAX);
   assign w_op_done   = !w_two_op || r_phase;
   assign w_last_op   = (r_elem == 3'd5) && w_addr_last;
   assign w_start     = (r_state == S_IDLE) && i_tmode;
   assign w_active    = (r_state == S_RUN) && i_tmode;
   assign w_is_read   = (r_elem == 3'd5) || (w_two_op && !r_phase);
   assign w_is_write  = (r_elem == 3'd0) || (w_two_op && r_phase);
   assign w_wr_one    = (r_elem == 3'd1) || (r_elem == 3'd3);
   assign w_rd_one    = (r_elem == 3'd2) || (r_elem == 3'd4);
   assign w_mismatch  = r_exp_valid && i_tmode &&
                        ((r_state == S_RUN) || (r_state == S_FLUSH)) &&
                        (i_mem_rdata != r_exp_data);

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_tmode) w_next = S_RUN;
         S_RUN:   begin
            if (!i_tmode)      w_next = S_IDLE;
            else if (w_last_op) w_next = S_FLUSH;
         end
         S_FLUSH: w_next = i_tmode ? S_DONE : S_IDLE;
         S_DONE:  if (!i_tmode) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Strobes are gated by tmode so an abort removes them in the same cycle.
   always_comb begin
      o_we    = 1'b0;
      o_re    = 1'b0;
      o_wdata = '0;
      if (w_active) begin
         o_we = w_is_write;
         o_re = w_is_read;
         if (w_is_write && w_wr_one) o_wdata = '1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || w_start) begin
         r_elem  <= 3'd0;
         r_phase <= 1'b0;
         r_addr  <= '0;
      end else if (w_active) begin
         if (!w_op_done) begin
            r_phase <= 1'b1;
         end else begin
            r_phase <= 1'b0;
            if (!w_addr_last) begin
               r_addr <= w_down ? r_addr - ADDR_W'(1) : r_addr + ADDR_W'(1);
            end else if (r_elem != 3'd5) begin
               r_elem <= r_elem + 3'd1;
               r_addr <= ((r_elem == 3'd2) || (r_elem == 3'd3)) ? ADDR_MAX : '0;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_exp_valid <= 1'b0;
         r_exp_data  <= '0;
         r_exp_addr  <= '0;
         r_exp_elem  <= 3'd0;
         r_stop      <= 1'b0;
         r_fail      <= 1'b0;
         r_fail_addr <= '0;
         r_fail_elem <= 3'd0;
      end else begin
         r_exp_valid <= o_re;
         if (o_re) begin
            r_exp_data <= w_rd_one ? '1 : '0;
            r_exp_addr <= r_addr;
            r_exp_elem <= r_elem;
         end
         r_stop <= (r_state == S_FLUSH) && i_tmode;
         if (w_start) begin
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= 3'd0;
         end else if (w_mismatch && !r_fail) begin
            r_fail      <= 1'b1;
            r_fail_addr <= r_exp_addr;
            r_fail_elem <= r_exp_elem;
         end
      end
   end

   assign o_addr      = r_addr;
   assign o_stop      = r_stop;
   assign o_fail      = r_fail;
   assign o_fail_addr = r_fail_addr;
   assign o_fail_elem = r_fail_elem;

endmodule

// File: tb/tb_march_engine.sv
// tb/tb_march_engine.sv - March C- engine bench: faulty RAM, op-list model, per-cycle compare.
module tb_march_engine;

   localparam int BIG = 32'h7fff_ffff;

   logic       clk = 1'b0;
   logic       rst;
   logic       tmode;
   logic [3:0] rdata;
   logic [7:0] o_addr;
   logic [3:0] o_wdata;
   logic       o_we, o_re, o_stop, o_fail;
   logic [7:0] o_fail_addr;
   logic [2:0] o_fail_elem;
   logic [26:0] out_v;

   int checks = 0;
   int errors = 0;
   int k = 0;
   int test_id = 0;
   bit chk_en = 1'b0;
   int ab_k = BIG;

   logic [7:0] f_addr = 8'h00;
   logic [3:0] f_m0 = 4'h0;
   logic [3:0] f_m1 = 4'h0;

   int         first_k = -1;
   logic [7:0] first_a = 8'h00;
   logic [2:0] first_e = 3'd0;

   logic [3:0] mem [256];

   march_engine #(.ADDR_W(8), .DATA_W(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_tmode(tmode), .i_mem_rdata(rdata),
      .o_addr(o_addr), .o_wdata(o_wdata), .o_we(o_we), .o_re(o_re),
      .o_stop(o_stop), .o_fail(o_fail), .o_fail_addr(o_fail_addr), .o_fail_elem(o_fail_elem)
   );

   assign out_v = {o_we, o_re, o_addr, o_wdata, o_stop, o_fail, o_fail_addr, o_fail_elem};

   always #5 clk = ~clk;

   function automatic logic [3:0] fault_rd(input logic [7:0] a, input logic [3:0] v);
      return (a == f_addr) ? ((v & ~f_m0) | f_m1) : v;
   endfunction

   always @(posedge clk) begin
      if (o_we) mem[o_addr] <= o_wdata;
      if (o_re) rdata <= fault_rd(o_addr, mem[o_addr]);
   end

   // Operation issued in cycle kk of a March C- pass (cycle 1 = first op).
   function automatic void op_at(input int kk, output logic we, output logic re,
                                 output logic [7:0] a, output logic [3:0] wd,
                                 output logic [3:0] rd, output logic [2:0] el);
      int j, r, ai;
      j = kk - 1;
      we = 1'b0; re = 1'b0; a = 8'h00; wd = 4'h0; rd = 4'h0; el = 3'd0;
      if (j >= 0 && j < 256) begin
         we = 1'b1;
         a  = 8'(j);
      end else if (j >= 256 && j < 2304) begin
         r  = j - 256;
         el = 3'(1 + r / 512);
         ai = (r % 512) / 2;
         if (el >= 3'd3) ai = 255 - ai;
         a = 8'(ai);
         if (r % 2 == 0) begin
            re = 1'b1;
            rd = (el == 3'd2 || el == 3'd4) ? 4'hF : 4'h0;
         end else begin
            we = 1'b1;
            wd = (el == 3'd1 || el == 3'd3) ? 4'hF : 4'h0;
         end
      end else if (j >= 2304 && j < 2560) begin
         re = 1'b1;
         el = 3'd5;
         a  = 8'(j - 2304);
      end
   endfunction

   function automatic void predict();
      logic [3:0] mm [256];
      logic we, re;
      logic [7:0] a;
      logic [3:0] wd, rd;
      logic [2:0] el;
      first_k = -1; first_a = 8'h00; first_e = 3'd0;
      for (int i = 0; i < 256; i++) mm[i] = 4'h0;
      for (int kk = 1; kk <= 2560; kk++) begin
         if (kk + 1 >= ab_k) break;
         op_at(kk, we, re, a, wd, rd, el);
         if (we) mm[a] = wd;
         if (re && first_k < 0 && fault_rd(a, mm[a]) != rd) begin
            first_k = kk; first_a = a; first_e = el;
         end
      end
   endfunction

   logic       e_we, e_re, e_stop, e_fail;
   logic [7:0] e_a;
   logic [3:0] e_wd, e_rd;
   logic [2:0] e_el;
   logic [26:0] exp_v, act_v;

   always @(negedge clk) begin
      if (chk_en) begin
         op_at(k, e_we, e_re, e_a, e_wd, e_rd, e_el);
         if (k >= ab_k) begin e_we = 1'b0; e_re = 1'b0; end
         e_stop = (k == 2562) && (ab_k > 2562);
         e_fail = (first_k >= 0) && (k >= first_k + 2);
         exp_v = {e_we, e_re, (e_we | e_re) ? e_a : 8'h00, e_we ? e_wd : 4'h0,
                  e_stop, e_fail, e_fail ? first_a : 8'h00, e_fail ? first_e : 3'd0};
         act_v = {o_we, o_re, (e_we | e_re) ? o_addr : 8'h00, e_we ? o_wdata : 4'h0,
                  o_stop, o_fail, o_fail_addr, o_fail_elem};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle t%0d k=%0d got %h want %h", test_id, k, act_v, exp_v);
         end
      end
   end

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t%0d k=%0d got %h want %h", nm, test_id, k, act, exp);
      end
   endtask

   task automatic lits(input int i);
      case (test_id)
         1: begin
            if (i == 257)  lit("e1_first", {o_re, o_addr}, {1'b1, 8'h00});
            if (i == 1281) lit("e3_first", {o_re, o_addr}, {1'b1, 8'hFF});
            if (i == 2561) lit("stop_early", o_stop, 0);
            if (i == 2562) lit("stop_t1", {o_stop, o_fail}, 2'b10);
         end
         2: begin
            if (i == 368)  lit("sa1_fail_pre", o_fail, 0);
            if (i == 369)  lit("sa1_fail_rise", o_fail, 1);
            if (i == 2562) lit("sa1_result", {o_stop, o_fail, o_fail_addr, o_fail_elem}, {2'b11, 8'h37, 3'd1});
         end
         3: begin
            if (i == 1000) lit("abort_strobes", {o_we, o_re}, 2'b00);
            if (i == 1010) lit("abort_hold", {o_fail, o_fail_addr, o_fail_elem}, {1'b1, 8'h37, 3'd1});
         end
         4: begin
            if (i == 1)    lit("restart_first", {o_we, o_addr, o_fail}, {1'b1, 8'h00, 1'b0});
            if (i == 2562) lit("restart_stop", {o_stop, o_fail}, 2'b10);
         end
         5: begin
            if (i == 1280) lit("sa0_fail_pre", o_fail, 0);
            if (i == 1281) lit("sa0_fail_rise", o_fail, 1);
            if (i == 2562) lit("sa0_result", {o_stop, o_fail, o_fail_addr, o_fail_elem}, {2'b11, 8'hFF, 3'd2});
         end
         6: if (i >= 1501) lit("rst_outs", out_v, 0);
         7: if (i == 1)    lit("post_rst_start", {o_we, o_addr}, {1'b1, 8'h00});
         default: ;
      endcase
   endtask

   task automatic run_test(input int id, input int abort_at, input int end_k, input int rst_at);
      test_id = id;
      ab_k = (abort_at == 0) ? BIG : abort_at;
      predict();
      k = 0;
      tmode = 1'b1;
      for (int i = 1; i <= end_k; i++) begin
         @(posedge clk);
         k = i;
         chk_en = (rst_at == 0) || (i <= rst_at);
         #1;
         if (i == abort_at) tmode = 1'b0;
         if (rst_at != 0 && i == rst_at) rst = 1'b1;
         if (rst_at != 0 && i == rst_at + 1) begin rst = 1'b0; tmode = 1'b0; end
         #1;
         lits(i);
      end
      @(negedge clk);
      #1;
      tmode = 1'b0;
      chk_en = 1'b0;
   endtask

   task automatic gap(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic set_fault(input logic [7:0] a, input logic [3:0] m0, input logic [3:0] m1);
      f_addr = a; f_m0 = m0; f_m1 = m1;
   endtask

   initial begin
      rst = 1'b1;
      tmode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      lit("reset_outs", out_v, 0);
      rst = 1'b0;
      gap(1);
      set_fault(8'h00, 4'h0, 4'h0); run_test(1, 0, 2662, 0);    gap(1);
      set_fault(8'h37, 4'h0, 4'h4); run_test(2, 0, 2565, 0);    gap(2);
      set_fault(8'h37, 4'h0, 4'h4); run_test(3, 1000, 1010, 0); gap(3);
      set_fault(8'h00, 4'h0, 4'h0); run_test(4, 0, 2565, 0);    gap(2);
      set_fault(8'hFF, 4'h1, 4'h0); run_test(5, 0, 2565, 0);    gap(2);
      set_fault(8'h37, 4'h0, 4'h4); run_test(6, 0, 1506, 1500); gap(3);
      set_fault(8'h00, 4'h0, 4'h0); run_test(7, 10, 12, 0);     gap(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/march_engine.md
# march_engine

March C- test sequencer for the 256x4 memory under BIST. It sits between the BIST controller and the memory wrapper. It runs a complete March C- pass while `tmode` is high and drives the memory address, data and strobes. It compares read data against expected values and returns a one-cycle `stop` pulse that ends test mode in the controller, together with a sticky pass/fail result.

## Interface
- `ADDR_W`, 8, memory address width (depth = 2^ADDR_W).
- `DATA_W`, 4, memory word width.

- `clk` in 1: single clock. All state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tmode` in 1: test-mode level from the BIST controller.
- `mem_rdata` in DATA_W: memory read data, valid the cycle after `re`.
- `addr` out ADDR_W: memory address.
- `wdata` out DATA_W: write data, all-0s or all-1s background.
- `we` out 1: memory write strobe.
- `re` out 1: memory read strobe.
- `stop` out 1: one-cycle pulse when the march completes. Drives the controller's `stop`.
- `fail` out 1: sticky mismatch flag.
- `fail_addr` out ADDR_W: address of the first mismatch.
- `fail_elem` out 3: march element (0-5) of the first mismatch.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- Reset values: state=IDLE; all outputs 0, including `addr`, `fail`, `fail_addr` and `fail_elem`.
- IDLE:
  - `we`=`re`=0.
  - On `tmode`=1, clear `fail`, `fail_addr` and `fail_elem`. Load elem=0, phase=0, addr=0. Next state RUN.
- RUN: one memory operation per cycle, in these elements:
  - e0 ⇕ w0: addresses up.
  - e1 ⇑ (r0, w1).
  - e2 ⇑ (r1, w0).
  - e3 ⇓ (r0, w1).
  - e4 ⇓ (r1, w0).
  - e5 ⇕ r0: addresses up.
- Two-op elements: phase 0 = read, phase 1 = write, on the same address. The address advances only after phase 1.
- Up elements count 0→255. Down elements count 255→0. Element change reloads addr (0 or 255) with no idle cycle.
- `wdata` equals the background of the current op: w0 → 4'h0, w1 → 4'hF.
- `we`/`re` are decoded from state/elem/phase and gated by `tmode`, so no strobe ever appears while `tmode`=0.
- Read check:
  - On each edge where `re`=1, register exp_valid=1, exp_data (r0 → 0, r1 → F), exp_addr and exp_elem.
  - The next cycle compares `mem_rdata` against exp_data.
  - On the first mismatch, the following edge sets `fail`=1 and captures `fail_addr`/`fail_elem`. Later mismatches leave the captured values unchanged.
- After the last e5 read (addr 255), next state FLUSH (one cycle, performs the final compare), then DONE.
- DONE:
  - `stop`=1 in the first DONE cycle only.
  - Stay in DONE while `tmode`=1. Never restart without `tmode` going low first.
  - On `tmode`=0, go to IDLE.
- Abort: `tmode`=0 in RUN or FLUSH goes to IDLE on the next edge.
  - Strobes drop immediately.
  - No `stop` pulse.
  - The pending compare is discarded.
  - `fail`/`fail_addr`/`fail_elem` hold their values.
- `rst` has priority over everything in every state, including mid-RUN. Result registers are cleared.

## Timing
- Cycle 0 = the edge sampling `tmode`=1 in IDLE.
  - RUN occupies cycles 1..2560 (256 + 4×512 + 256 ops).
  - FLUSH is cycle 2561.
  - `stop`=1 in cycle 2562.
- `fail` is final in the `stop` cycle and holds until the next test start or `rst`.
- Read latency 1: a read issued in cycle n is compared in cycle n+1, and `fail` is visible in cycle n+2.
- First e1 op: cycle 257, r0 @ addr 0. First e3 op: cycle 1281, r0 @ addr 255.
- A mismatch on the final e5 read (cycle 2560) is reported by the `stop` cycle.

## Test plan
- Fault-free RAM model, `tmode` held high from cycle 0 → 2560 strobes, `stop` pulse exactly at cycle 2562, `fail`=0. Returns to IDLE the cycle after `tmode` drops.
- Stuck-at-1 on bit 2 @ addr 0x37 → `fail`=1, `fail_addr`=0x37, `fail_elem`=1 (first r0 at that address). `stop` still at 2562.
- Stuck-at-0 on bit 0 @ addr 0xFF → `fail`=1, `fail_addr`=0xFF, `fail_elem`=2.
- `tmode` dropped at cycle 1000 → `we`/`re`=0 in cycle 1000, state IDLE by 1001, no `stop`. A restart runs the full 2560 ops from addr 0 and clears `fail`.
- `rst` asserted at cycle 1500 → all outputs 0 next cycle, and the engine does not restart until `tmode` is sampled high again in IDLE.
- `tmode` held high for 100 cycles after `stop` → single `stop` pulse, no strobes, state stays DONE.
